// File: rtl/pe_pkg.sv
// Shared types and constants for the PE data feeder and its stream buffer.
package pe_pkg;

   // Default control-bus field widths.
   localparam int KL_ROW_W = 2;
   localparam int KL_COL_W = 2;

   // Control-bus token types: a lock programs a PE, a key tags a data word.
   localparam logic KL_LOCK = 1'b0;
   localparam logic KL_KEY  = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FLUSH  = 3'd1,
      ST_LOCK   = 3'd2,
      ST_STREAM = 3'd3,
      ST_DRAIN  = 3'd4
   } feeder_state_e;

   typedef struct packed {
      logic [KL_ROW_W-1:0] row;
      logic [KL_COL_W-1:0] col;
      logic                kl_type;
   } kl_bus_t;

   // Address width of a buffer; one extra pointer bit is added by the user.
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/pe_data_feeder_if.sv
// Handshake and PE-bus bundle between the upstream job source and the feeder.
interface pe_data_feeder_if #(
   parameter int PE_WIDTH      = 16,
   parameter int ROW_BUS_WIDTH = 2,
   parameter int COL_BUS_WIDTH = 2
);
   // Job start
   logic                     flush_req;

   // Lock-programming channel
   logic                     cfg_valid;
   logic                     cfg_ready;
   logic [ROW_BUS_WIDTH-1:0] cfg_row;
   logic [COL_BUS_WIDTH-1:0] cfg_col;
   logic                     cfg_last;

   // Data-stream channel
   logic                     s_valid;
   logic                     s_ready;
   logic [PE_WIDTH-1:0]      s_fmap;
   logic [PE_WIDTH-1:0]      s_fltr;
   logic [ROW_BUS_WIDTH-1:0] s_row;
   logic [COL_BUS_WIDTH-1:0] s_col;
   logic                     s_last;

   // PE-side outputs and status
   logic                     pe_flush;
   logic [PE_WIDTH-1:0]      pe_fmap;
   logic [PE_WIDTH-1:0]      pe_fltr;
   logic [ROW_BUS_WIDTH-1:0] pe_kl_row;
   logic [COL_BUS_WIDTH-1:0] pe_kl_col;
   logic                     pe_kl_type;
   logic                     pe_kl_vld;
   logic                     busy;
   logic                     done;

   // Job source side
   modport master (
      output flush_req,
      output cfg_valid, cfg_row, cfg_col, cfg_last,
      input  cfg_ready,
      output s_valid, s_fmap, s_fltr, s_row, s_col, s_last,
      input  s_ready,
      input  pe_flush, pe_fmap, pe_fltr, pe_kl_row, pe_kl_col, pe_kl_type, pe_kl_vld,
      input  busy, done
   );

   // Feeder side
   modport slave (
      input  flush_req,
      input  cfg_valid, cfg_row, cfg_col, cfg_last,
      output cfg_ready,
      input  s_valid, s_fmap, s_fltr, s_row, s_col, s_last,
      output s_ready,
      output pe_flush, pe_fmap, pe_fltr, pe_kl_row, pe_kl_col, pe_kl_type, pe_kl_vld,
      output busy, done
   );

endinterface

// File: rtl/pe_feed_fifo.sv
// Small stream buffer: synchronous push/pop, wrap-bit pointers, async reset.
// Read data is taken straight from the head slot so a pop can be registered
// by the consumer in the same cycle.
module pe_feed_fifo
   import pe_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = ptr_width(DEPTH);

   logic [AW:0]      wr_ptr_reg;
   logic [AW:0]      rd_ptr_reg;
   logic [AW-1:0]    wr_addr;
   logic [AW-1:0]    rd_addr;
   logic [WIDTH-1:0] mem_reg [DEPTH];
   logic [DEPTH-1:0] wr_en;
   logic             do_push;
   logic             do_pop;

   assign wr_addr = wr_ptr_reg[AW-1:0];
   assign rd_addr = rd_ptr_reg[AW-1:0];

   // Same address with different wrap bits means the writer lapped the reader.
   assign empty = (wr_ptr_reg == rd_ptr_reg);
   assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) && (wr_addr == rd_addr);

   // Overflow and underflow requests are dropped here as a safety net.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // One write strobe per slot.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
         assign wr_en[gi] = do_push && (wr_addr == AW'(gi));
      end
   endgenerate

   // Slot storage; contents need no reset because the pointers define validity.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (wr_en[i]) begin
            mem_reg[i] <= wdata;
         end
      end
   end

   // Pointer advance, cleared asynchronously to empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
         end
      end
   end

   assign rdata = mem_reg[rd_addr];

endmodule

// File: rtl/pe_data_feeder.sv
// PE data feeder: flushes the PE array, programs locks, then streams keyed
// fmap/filter words through a small buffer and waits out the PE latency.
module pe_data_feeder
   import pe_pkg::*;
#(
   parameter int PE_WIDTH      = 16,
   parameter int ROW_BUS_WIDTH = KL_ROW_W,
   parameter int COL_BUS_WIDTH = KL_COL_W,
   parameter int FIFO_DEPTH    = 4,
   parameter int DRAIN_CYCLES  = 11
)(
   input  logic           clk,
   input  logic           rst,
   pe_data_feeder_if.slave bus
);

   localparam int ENTRY_W = 2*PE_WIDTH + ROW_BUS_WIDTH + COL_BUS_WIDTH + 1;
   localparam int CNT_W   = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   feeder_state_e            state_reg;
   logic [CNT_W-1:0]         drain_cnt_reg;
   logic                     last_seen_reg;

   logic                     pe_flush_reg;
   logic                     kl_vld_reg;
   logic                     kl_type_reg;
   logic [ROW_BUS_WIDTH-1:0] kl_row_reg;
   logic [COL_BUS_WIDTH-1:0] kl_col_reg;
   logic [PE_WIDTH-1:0]      fmap_reg;
   logic [PE_WIDTH-1:0]      fltr_reg;
   logic                     done_reg;

   logic                     fifo_full;
   logic                     fifo_empty;
   logic                     s_ready_int;
   logic                     push;
   logic                     pop;
   logic [ENTRY_W-1:0]       wr_entry;
   logic [ENTRY_W-1:0]       rd_entry;

   logic                     rd_last;
   logic [ROW_BUS_WIDTH-1:0] rd_row;
   logic [COL_BUS_WIDTH-1:0] rd_col;
   logic [PE_WIDTH-1:0]      rd_fmap;
   logic [PE_WIDTH-1:0]      rd_fltr;

   // Once the end-of-job word is in, nothing more is accepted for this job.
   assign s_ready_int = (state_reg == ST_STREAM) && !fifo_full && !last_seen_reg;
   assign push        = bus.s_valid && s_ready_int;

   // The PE side never stalls, so the head is drained every cycle in STREAM.
   // A word pushed into an empty buffer is popped one cycle later.
   assign pop         = (state_reg == ST_STREAM) && !fifo_empty;

   assign wr_entry = {bus.s_last, bus.s_row, bus.s_col, bus.s_fmap, bus.s_fltr};
   assign {rd_last, rd_row, rd_col, rd_fmap, rd_fltr} = rd_entry;

   pe_feed_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata (wr_entry),
      .rdata (rd_entry),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Job sequencer with registered PE bus; the bus returns to zero whenever
   // no token is issued.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         drain_cnt_reg <= '0;
         last_seen_reg <= 1'b0;
         pe_flush_reg  <= 1'b0;
         kl_vld_reg    <= 1'b0;
         kl_type_reg   <= 1'b0;
         kl_row_reg    <= '0;
         kl_col_reg    <= '0;
         fmap_reg      <= '0;
         fltr_reg      <= '0;
         done_reg      <= 1'b0;
      end else begin
         pe_flush_reg <= 1'b0;
         kl_vld_reg   <= 1'b0;
         kl_type_reg  <= 1'b0;
         kl_row_reg   <= '0;
         kl_col_reg   <= '0;
         fmap_reg     <= '0;
         fltr_reg     <= '0;
         done_reg     <= 1'b0;

         case (state_reg)
            ST_IDLE: begin
               if (bus.flush_req) begin
                  state_reg     <= ST_FLUSH;
                  pe_flush_reg  <= 1'b1;
                  last_seen_reg <= 1'b0;
                  drain_cnt_reg <= '0;
               end
            end

            ST_FLUSH: begin
               state_reg <= ST_LOCK;
            end

            ST_LOCK: begin
               if (bus.cfg_valid) begin
                  kl_vld_reg  <= 1'b1;
                  kl_type_reg <= KL_LOCK;
                  kl_row_reg  <= bus.cfg_row;
                  kl_col_reg  <= bus.cfg_col;
                  if (bus.cfg_last) begin
                     state_reg <= ST_STREAM;
                  end
               end
            end

            ST_STREAM: begin
               if (push && bus.s_last) begin
                  last_seen_reg <= 1'b1;
               end
               if (pop) begin
                  kl_vld_reg  <= 1'b1;
                  kl_type_reg <= KL_KEY;
                  kl_row_reg  <= rd_row;
                  kl_col_reg  <= rd_col;
                  fmap_reg    <= rd_fmap;
                  fltr_reg    <= rd_fltr;
                  if (rd_last) begin
                     state_reg     <= ST_DRAIN;
                     drain_cnt_reg <= '0;
                  end
               end
            end

            ST_DRAIN: begin
               if (drain_cnt_reg == CNT_W'(DRAIN_CYCLES - 1)) begin
                  state_reg <= ST_IDLE;
                  done_reg  <= 1'b1;
               end else begin
                  drain_cnt_reg <= drain_cnt_reg + CNT_W'(1);
               end
            end

            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.cfg_ready  = (state_reg == ST_LOCK);
   assign bus.s_ready    = s_ready_int;
   assign bus.pe_flush   = pe_flush_reg;
   assign bus.pe_fmap    = fmap_reg;
   assign bus.pe_fltr    = fltr_reg;
   assign bus.pe_kl_row  = kl_row_reg;
   assign bus.pe_kl_col  = kl_col_reg;
   assign bus.pe_kl_type = kl_type_reg;
   assign bus.pe_kl_vld  = kl_vld_reg;
   assign bus.busy       = (state_reg != ST_IDLE);
   assign bus.done       = done_reg;

endmodule

// File: tb/tb_pe_data_feeder.sv
// Randomized bench for pe_data_feeder. The reference model tracks each job as
// a timeline of edges (flush, stream start, per-word pop, done) and a queue of
// expected PE tokens, and every cycle compares the PE bus and status outputs.
module tb_pe_data_feeder;
   import pe_pkg::*;

   localparam int PW    = 16;
   localparam int RW    = 2;
   localparam int CW    = 2;
   localparam int DEPTH = 4;
   localparam int DRAIN = 11;
   localparam int INF   = 32'h3fff_ffff;
   localparam int BUDGET = 1000;

   logic clk;
   logic rst;

   pe_data_feeder_if #(.PE_WIDTH(PW), .ROW_BUS_WIDTH(RW), .COL_BUS_WIDTH(CW)) bus();

   pe_data_feeder #(
      .PE_WIDTH      (PW),
      .ROW_BUS_WIDTH (RW),
      .COL_BUS_WIDTH (CW),
      .FIFO_DEPTH    (DEPTH),
      .DRAIN_CYCLES  (DRAIN)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int            edge_no;
      kl_bus_t       kl;
      logic [PW-1:0] fmap;
      logic [PW-1:0] fltr;
   } tok_t;

   tok_t tokq[$];
   int   pend[$];

   int edge_cnt = 0;
   int checks   = 0;
   int errors   = 0;
   int key_seen = 0;

   bit job_active  = 0;
   bit last_pushed = 0;
   bit cfg_fired   = 0;
   bit s_fired     = 0;
   int flush_edge, stream_edge, last_pop_edge, done_edge, prev_pop;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s @edge %0d: got %h expected %h", tag, edge_cnt, got, exp);
      end
   endtask

   function automatic bit in_idle(input int k);
      return !job_active || (k >= done_edge);
   endfunction

   function automatic bit in_lock(input int k);
      return job_active && (k > flush_edge) && (k < stream_edge);
   endfunction

   function automatic bit in_stream(input int k);
      return job_active && (k >= stream_edge) && (k < last_pop_edge);
   endfunction

   function automatic bit exp_s_ready(input int k);
      return in_stream(k) && (pend.size() < DEPTH) && !last_pushed;
   endfunction

   task automatic model_reset();
      job_active    = 0;
      last_pushed   = 0;
      flush_edge    = INF;
      stream_edge   = INF;
      last_pop_edge = INF;
      done_edge     = INF;
      prev_pop      = 0;
      tokq.delete();
      pend.delete();
   endtask

   // Compare everything visible now against the model at the current edge.
   task automatic compare_all();
      int         k;
      logic [37:0] exp_kl;
      logic [37:0] got_kl;
      logic [4:0]  exp_ctrl;
      logic [4:0]  got_ctrl;
      k = edge_cnt;
      while (pend.size() > 0 && pend[0] <= k) pend.delete(0);
      exp_kl = '0;
      if (tokq.size() > 0 && tokq[0].edge_no == k) begin
         exp_kl = {1'b1, tokq[0].kl.kl_type, tokq[0].kl.row, tokq[0].kl.col,
                   tokq[0].fmap, tokq[0].fltr};
         tokq.delete(0);
      end
      got_kl = {bus.pe_kl_vld, bus.pe_kl_type, bus.pe_kl_row, bus.pe_kl_col,
                bus.pe_fmap, bus.pe_fltr};
      check("kl_bus", 64'(got_kl), 64'(exp_kl));
      exp_ctrl = {job_active && (k == flush_edge),
                  in_lock(k),
                  exp_s_ready(k),
                  job_active && (k >= flush_edge) && (k < done_edge),
                  job_active && (k == done_edge)};
      got_ctrl = {bus.pe_flush, bus.cfg_ready, bus.s_ready, bus.busy, bus.done};
      check("flush_cfgrdy_srdy_busy_done", 64'(got_ctrl), 64'(exp_ctrl));
      if (bus.pe_kl_vld && bus.pe_kl_type) key_seen++;
   endtask

   task automatic tick();
      @(posedge clk);
      edge_cnt++;
      @(negedge clk);
      compare_all();
   endtask

   // Apply the current inputs to the model for the coming edge, then clock.
   task automatic step();
      int   k;
      int   e;
      int   pop_e;
      bit   sr;
      bit   lk;
      bit   idl;
      tok_t t;
      k   = edge_cnt;
      e   = k + 1;
      sr  = exp_s_ready(k);
      lk  = in_lock(k);
      idl = in_idle(k);
      cfg_fired = bus.cfg_valid && lk;
      s_fired   = bus.s_valid && sr;
      if (bus.flush_req && idl) begin
         model_reset();
         job_active = 1;
         flush_edge = e;
      end
      if (cfg_fired) begin
         t.edge_no    = e;
         t.kl.row     = bus.cfg_row;
         t.kl.col     = bus.cfg_col;
         t.kl.kl_type = KL_LOCK;
         t.fmap       = '0;
         t.fltr       = '0;
         tokq.push_back(t);
         if (bus.cfg_last) stream_edge = e;
      end
      if (s_fired) begin
         pop_e = (e + 1 > prev_pop + 1) ? e + 1 : prev_pop + 1;
         prev_pop     = pop_e;
         t.edge_no    = pop_e;
         t.kl.row     = bus.s_row;
         t.kl.col     = bus.s_col;
         t.kl.kl_type = KL_KEY;
         t.fmap       = bus.s_fmap;
         t.fltr       = bus.s_fltr;
         tokq.push_back(t);
         pend.push_back(pop_e);
         if (bus.s_last) begin
            last_pushed   = 1;
            last_pop_edge = pop_e;
            done_edge     = pop_e + DRAIN;
         end
      end
      tick();
   endtask

   task automatic clear_inputs();
      bus.flush_req = 1'b0;
      bus.cfg_valid = 1'b0;
      bus.cfg_row   = '0;
      bus.cfg_col   = '0;
      bus.cfg_last  = 1'b0;
      bus.s_valid   = 1'b0;
      bus.s_fmap    = '0;
      bus.s_fltr    = '0;
      bus.s_row     = '0;
      bus.s_col     = '0;
      bus.s_last    = 1'b0;
   endtask

   task automatic mid_job_reset();
      clear_inputs();
      rst = 1'b1;
      model_reset();
      #1;
      compare_all();
      tick();
      tick();
      rst = 1'b0;
   endtask

   // One full job; abort_at > 0 asserts reset right after that many pushes.
   task automatic run_job(input int nw, input bit directed, input int vpct,
                          input bit noise, input int abort_at);
      logic [PW-1:0] fm [16];
      logic [PW-1:0] fl [16];
      logic [RW-1:0] rw [16];
      logic [CW-1:0] cl [16];
      logic [RW-1:0] crow [4];
      logic [CW-1:0] ccol [4];
      int ncfg;
      int cpct;
      int ci;
      int wi;
      int budget;
      bit aborted;
      ci = 0; wi = 0; budget = 0; aborted = 0;
      key_seen = 0;
      if (directed) begin
         ncfg = 2; cpct = 100;
         crow[0] = 2'd0; ccol[0] = 2'd1;
         crow[1] = 2'd1; ccol[1] = 2'd0;
         for (int i = 0; i < nw; i++) begin
            fm[i] = PW'(i + 1);
            fl[i] = PW'($urandom);
            rw[i] = 2'd0;
            cl[i] = 2'd1;
         end
      end else begin
         ncfg = $urandom_range(1, 3); cpct = 70;
         for (int i = 0; i < ncfg; i++) begin
            crow[i] = RW'($urandom);
            ccol[i] = CW'($urandom);
         end
         for (int i = 0; i < nw; i++) begin
            fm[i] = PW'($urandom);
            fl[i] = PW'($urandom);
            rw[i] = RW'($urandom);
            cl[i] = CW'($urandom);
         end
      end

      bus.flush_req = 1'b1;
      step();
      bus.flush_req = 1'b0;

      while (!in_idle(edge_cnt) && budget < BUDGET) begin
         bus.cfg_valid = (ci < ncfg) && ($urandom_range(0, 99) < cpct);
         bus.cfg_row   = (ci < ncfg) ? crow[ci] : '0;
         bus.cfg_col   = (ci < ncfg) ? ccol[ci] : '0;
         bus.cfg_last  = (ci == ncfg - 1);
         bus.s_valid   = (wi < nw) && ($urandom_range(0, 99) < vpct);
         bus.s_fmap    = (wi < nw) ? fm[wi] : '0;
         bus.s_fltr    = (wi < nw) ? fl[wi] : '0;
         bus.s_row     = (wi < nw) ? rw[wi] : '0;
         bus.s_col     = (wi < nw) ? cl[wi] : '0;
         bus.s_last    = (wi == nw - 1);
         bus.flush_req = noise && ($urandom_range(0, 99) < 25);
         step();
         if (cfg_fired) ci++;
         if (s_fired) begin
            wi++;
            if (wi == abort_at) begin
               mid_job_reset();
               aborted = 1;
               break;
            end
         end
         budget++;
      end
      clear_inputs();
      if (!aborted) begin
         check("job_timeout", 64'(budget < BUDGET), 64'd1);
         check("key_count", 64'(key_seen), 64'(nw));
      end
   endtask

   initial begin
      clear_inputs();
      model_reset();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;

      // Directed lock/stream job, then same with flush_req noise
      run_job(4, 1'b1, 100, 1'b0, 0);
      repeat (3) step();
      run_job(4, 1'b1, 100, 1'b1, 0);

      // Reset mid-stream, then a clean job straight after release
      run_job(6, 1'b0, 100, 1'b0, 3);
      run_job(5, 1'b0, 100, 1'b0, 0);

      // Random gaps, random keys, flush_req noise
      for (int j = 0; j < 6; j++) begin
         run_job(8, 1'b0, 60, 1'b1, 0);
         repeat ($urandom_range(0, 3)) step();
      end

      repeat (5) step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pe_data_feeder.md
PE_DATA_FEEDER -- requirements
Module: pe_data_feeder

Interface
REQ-001 SHALL have parameter PE_WIDTH, default 16, data word width for fmap and filter.
REQ-002 SHALL have parameter ROW_BUS_WIDTH, default 2, row-ID width.
REQ-003 SHALL have parameter COL_BUS_WIDTH, default 2, column-ID width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4 (power of two, at least 2), stream buffer entries.
REQ-005 SHALL have parameter DRAIN_CYCLES, default 11, which is the downstream PE latency (its delay plus 1).
REQ-006 SHALL have port clk  in  1  clock; all flops on the rising edge.
REQ-007 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-008 SHALL have port flush_req  in  1  starts a configure+stream job; sampled only in IDLE.
REQ-009 SHALL have ports cfg_valid/cfg_ready  in/out  1/1  lock-programming handshake.
REQ-010 SHALL have ports cfg_row, cfg_col, cfg_last  in  ROW_BUS_WIDTH, COL_BUS_WIDTH, 1  lock ID and last-lock flag.
REQ-011 SHALL have ports s_valid/s_ready  in/out  1/1  data-stream handshake.
REQ-012 SHALL have ports s_fmap, s_fltr  in  PE_WIDTH each  fmap and filter words.
REQ-013 SHALL have ports s_row, s_col, s_last  in  ROW_BUS_WIDTH, COL_BUS_WIDTH, 1  destination key and end-of-job flag.
REQ-014 SHALL have port pe_flush  out  1  PE configuration reset.
REQ-015 SHALL have ports pe_fmap, pe_fltr  out  PE_WIDTH each  PE data inputs.
REQ-016 SHALL have ports pe_kl_row, pe_kl_col, pe_kl_type, pe_kl_vld  out  ROW_BUS_WIDTH, COL_BUS_WIDTH, 1, 1  control bus; kl_type 0 = lock, 1 = key.
REQ-017 SHALL have ports busy, done  out  1, 1  busy means state is not IDLE; done is a one-cycle job-complete pulse.

Function
REQ-018 SHALL implement FSM states IDLE, FLUSH, LOCK, STREAM, DRAIN.
REQ-019 In IDLE, flush_req=1 SHALL move to FLUSH; flush_req in any other state SHALL be ignored.
REQ-020 FLUSH SHALL last exactly 1 cycle with pe_flush=1, then move to LOCK.
REQ-021 In LOCK, cfg_ready SHALL be 1; each accepted beat SHALL drive, registered on the next cycle, pe_kl_vld=1, pe_kl_type=0, and row/col=cfg_row/cfg_col for one cycle.
REQ-022 An accepted beat with cfg_last=1 SHALL move LOCK to STREAM.
REQ-023 s_ready SHALL equal "FIFO not full" in STREAM and SHALL be 0 in all other states; a push occurs on s_valid&&s_ready.
REQ-024 In STREAM, a non-empty FIFO SHALL pop one entry per cycle; the popped entry SHALL drive, registered on the next cycle, pe_fmap/pe_fltr, pe_kl_vld=1, pe_kl_type=1, and row/col=its key.
REQ-025 Minimum latency from push to PE output SHALL be 2 cycles when the FIFO is empty; with FIFO_DEPTH=4, full throughput SHALL be 1 word/cycle.
REQ-026 Simultaneous push and pop when the FIFO is full SHALL NOT occur, because s_ready=0 when full; a simultaneous push and pop when the FIFO is empty SHALL occur only as a push, with the pop happening the following cycle.
REQ-027 Popping the entry with s_last=1 SHALL move the FSM to DRAIN; after s_last is accepted, s_ready SHALL be 0.
REQ-028 DRAIN SHALL count DRAIN_CYCLES cycles, then pulse done=1 for 1 cycle and return to IDLE.
REQ-029 On every cycle without a valid token, pe_kl_vld SHALL be 0, row/col/type SHALL be 0, and pe_fmap/pe_fltr SHALL hold 0.
REQ-030 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with an extra pointer bit distinguishing full from empty.

Reset
REQ-031 rst=1 SHALL asynchronously force state IDLE, empty FIFO, cleared drain counter, and all outputs 0.
REQ-032 rst asserted mid-job SHALL discard buffered data, with no done pulse.
REQ-033 After rst release, the first flush_req SHALL be accepted on the first clock edge.

Structure
REQ-034 A shared package pe_pkg SHALL hold the kl_bus_t packed struct (row, col, kl_type), the feeder_state_e enum, and the KL_LOCK=0 and KL_KEY=1 constants.
REQ-035 The FIFO SHALL be a separate sub-module, pe_feed_fifo, with synchronous push/pop, full/empty outputs, and asynchronous rst.

Verification
REQ-036 flush_req, then 2 cfg beats (0,1) and (1,0, last) -> pe_flush high for 1 cycle; lock tokens (type 0) on 2 consecutive cycles; state STREAM.
REQ-037 Stream 4 words: fmap=0x0001..0x0004, key (0,1), last on word 4 -> 4 consecutive key tokens each 2 cycles after push; DRAIN; done pulses 11 cycles after the last token.
REQ-038 Hold s_valid with no pops stalled -> s_ready=0 after 4 pushes; no data lost; output order preserved.
REQ-039 Assert rst during STREAM with 3 words buffered -> all outputs 0 immediately; IDLE; no done; next job runs cleanly.
REQ-040 Pulse flush_req during STREAM and during DRAIN -> no effect; pe_flush stays 0.
REQ-041 Stream 8 words with random s_valid gaps -> a gap cycle gives pe_kl_vld=0 and bus 0; output count 8.
